// File: rtl/enc_pkg.sv
// Shared definitions for the round-robin 8-to-3 encoder: sizes, FSM encodings
// and the rotating priority select.
package enc_pkg;

  localparam int unsigned N = 8;
  localparam int unsigned W = 3;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_VALID = 1'b1;

  // First set bit of mask scanning ptr, ptr+1, ... with wrap; returns ptr if mask is empty.
  function automatic logic [W-1:0] rr_select(input logic [N-1:0] mask,
                                             input logic [W-1:0] ptr);
    logic [W-1:0] idx;
    logic [W-1:0] sel;
    logic         found;
    sel   = ptr;
    found = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = ptr + W'(i);
      if (!found && mask[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/dec3to8_case.sv
// Case-based 3-to-8 decoder with enable; all-zero output when disabled.
module dec3to8_case
  import enc_pkg::*;
(
  input  logic         en,
  input  logic [W-1:0] in,
  output logic [N-1:0] out
);

  always_comb begin
    out = '0;
    if (en) begin
      case (in)
        3'd0:    out = 8'h01;
        3'd1:    out = 8'h02;
        3'd2:    out = 8'h04;
        3'd3:    out = 8'h08;
        3'd4:    out = 8'h10;
        3'd5:    out = 8'h20;
        3'd6:    out = 8'h40;
        3'd7:    out = 8'h80;
        default: out = '0;
      endcase
    end
  end

endmodule

// File: rtl/enc8to3_rr.sv
// Round-robin 8-to-3 request encoder: latches multi-hot requests into a pending
// mask and presents one index per transfer on a valid/ready output.
module enc8to3_rr
  import enc_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [N-1:0] in,
  output logic [W-1:0] out,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] pending,
  output logic         ovf
);

  logic [0:0]   state;
  logic [0:0]   state_nxt;
  logic [W-1:0] ptr;
  logic [W-1:0] ptr_nxt;
  logic [W-1:0] out_nxt;

  logic         acc_c;
  logic [N-1:0] set_c;
  logic [N-1:0] clr_c;
  logic [N-1:0] rem_c;
  logic [W-1:0] ptr_adv_c;

  assign acc_c     = out_valid & out_ready;
  assign set_c     = en ? in : '0;
  assign rem_c     = pending & ~clr_c;
  assign ptr_adv_c = out + W'(1);

  dec3to8_case u_clr_dec (
    .en  (acc_c),
    .in  (out),
    .out (clr_c)
  );

  // Set wins over clear; overflow flags a capture onto a bit that survives this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
      ovf     <= 1'b0;
    end else begin
      pending <= (pending & ~clr_c) | set_c;
      ovf     <= |(set_c & pending & ~clr_c);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      ptr       <= '0;
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      out       <= out_nxt;
      out_valid <= (state_nxt == S_VALID);
    end
  end

  // Selection sees only the registered mask, so same-cycle captures wait a turn.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    out_nxt   = out;
    case (state)
      S_IDLE: begin
        if (pending != '0) begin
          out_nxt   = rr_select(pending, ptr);
          state_nxt = S_VALID;
        end
      end
      S_VALID: begin
        if (acc_c) begin
          ptr_nxt = ptr_adv_c;
          if (rem_c != '0) begin
            out_nxt = rr_select(rem_c, ptr_adv_c);
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_enc8to3_rr.sv
// Directed self-checking bench for the round-robin 8-to-3 encoder.
module tb_enc8to3_rr;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] in;
  logic [2:0] out;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] pending;
  logic       ovf;

  int n_cmp;
  int n_err;

  enc8to3_rr dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .in        (in),
    .out       (out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pending   (pending),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [2:0] code);
    chk({tag, "_valid"}, 8'(out_valid), 8'h01);
    chk({tag, "_out"}, 8'(out), 8'(code));
  endtask

  task automatic capture(input logic [7:0] req);
    en = 1'b1;
    in = req;
    tick();
    en = 1'b0;
    in = 8'h00;
  endtask

  task automatic reset_pulse();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out",     8'(out),       8'h00);
    chk("rst_valid",   8'(out_valid), 8'h00);
    chk("rst_pending", pending,       8'h00);
    chk("rst_ovf",     8'(ovf),       8'h00);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    en        = 1'b0;
    in        = 8'h00;
    out_ready = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    chk("init_valid",   8'(out_valid), 8'h00);
    chk("init_pending", pending,       8'h00);
    chk("init_ovf",     8'(ovf),       8'h00);
    chk("init_out",     8'(out),       8'h00);

    // Single request from ptr=0: out=5 for one cycle, ptr -> 6
    out_ready = 1'b1;
    capture(8'h20);
    chk("single_pend", pending, 8'h20);
    chk("single_lat", 8'(out_valid), 8'h00);
    tick();
    chk_out("single", 3'd5);
    tick();
    chk("single_done", 8'(out_valid), 8'h00);
    chk("single_clr", pending, 8'h00);

    // Asynchronous reset mid-transfer with requests pending
    out_ready = 1'b0;
    capture(8'h0F);
    tick();
    chk_out("pre_rst", 3'd0);
    reset_pulse();
    out_ready = 1'b1;
    capture(8'h10);
    tick();
    chk_out("post_rst", 3'd4);
    tick();
    chk("post_rst_done", 8'(out_valid), 8'h00);
    reset_pulse();

    // Round-robin from ptr=0: 0, 2, 7 back-to-back
    capture(8'h85);
    tick();
    chk_out("rr0", 3'd0);
    tick();
    chk_out("rr2", 3'd2);
    tick();
    chk_out("rr7", 3'd7);
    tick();
    chk("rr_done", 8'(out_valid), 8'h00);
    chk("rr_pend", pending, 8'h00);
    // ptr wrapped to 0: 0 then 7
    capture(8'h81);
    tick();
    chk_out("wrap0", 3'd0);
    tick();
    chk_out("wrap7", 3'd7);
    tick();
    chk("wrap_done", 8'(out_valid), 8'h00);
    // Single accept of 0 leaves ptr=1, so 0x81 gives 7 before 0
    capture(8'h01);
    tick();
    chk_out("one0", 3'd0);
    tick();
    capture(8'h81);
    tick();
    chk_out("ptr1_7", 3'd7);
    tick();
    chk_out("ptr1_0", 3'd0);
    tick();
    chk("ptr1_done", 8'(out_valid), 8'h00);

    // Backpressure from ptr=1 with bits 0,3,6: out=3 held
    out_ready = 1'b0;
    capture(8'h49);
    tick();
    for (int i = 0; i < 10; i++) begin
      chk_out("hold", 3'd3);
      tick();
    end
    capture(8'h08);
    chk("bp_ovf", 8'(ovf), 8'h01);
    chk("bp_pend", pending, 8'h49);
    chk_out("bp_still", 3'd3);
    tick();
    chk("bp_ovf_pulse", 8'(ovf), 8'h00);
    out_ready = 1'b1;
    tick();
    chk_out("drain6", 3'd6);
    tick();
    chk_out("drain0", 3'd0);
    tick();
    chk("drain_done", 8'(out_valid), 8'h00);
    chk("drain_pend", pending, 8'h00);

    // Enable gating
    en = 1'b0;
    in = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("gate_pend", pending, 8'h00);
      chk("gate_valid", 8'(out_valid), 8'h00);
      chk("gate_ovf", 8'(ovf), 8'h00);
    end
    in = 8'h00;

    // Set/clear collision on bit 3, ptr=1
    out_ready = 1'b0;
    capture(8'h28);
    tick();
    chk_out("col_pre", 3'd3);
    out_ready = 1'b1;
    capture(8'h08);
    chk_out("col_next5", 3'd5);
    chk("col_pend", pending, 8'h28);
    chk("col_ovf", 8'(ovf), 8'h00);
    tick();
    chk_out("col_again3", 3'd3);
    chk("col_pend2", pending, 8'h08);
    tick();
    chk("col_done", 8'(out_valid), 8'h00);
    chk("col_empty", pending, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/enc8to3_rr.md
# enc8to3_rr

Round-robin 8-to-3 request encoder, the encoding counterpart of the 3-to-8 decoders (`dec3to8_shift`, `dec3to8_case`). It latches multi-hot request lines into a pending mask and emits one 3-bit index per accepted transfer on a valid/ready output. Indices are chosen round-robin so no request line starves. It feeds any consumer that takes a binary index, typically a `dec3to8_*` instance that turns it back into a one-hot strobe.

## Interface
- `N`, 8: number of request lines; fixed at 8 in this revision.
- `W`, 3: index width, `N == 2**W`.

- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `en`  in  1  request capture enable; when 0, `in` is ignored.
- `in`  in  N  request lines, level-sampled each cycle, multi-hot allowed.
- `out`  out  W  encoded index of the presented request.
- `out_valid`  out  1  `out` holds a valid index.
- `out_ready`  in  1  consumer accepts `out` this cycle.
- `pending`  out  N  registered pending-request mask.
- `ovf`  out  1  one-cycle pulse: a captured request hit a bit that was already pending and is not being cleared.

## Operation
- Capture: `set = en ? in : 0`.
- Accept: `acc = out_valid & out_ready`. Clear mask: `clr = acc ? onehot(out) : 0`.
- Pending update every cycle: `pending <= (pending & ~clr) | set`. Set wins over clear on the same bit.
- `ovf <= |(set & pending & ~clr)`.
- Round-robin pointer `ptr` (W bits) sets the scan start. The select function returns the first set bit of a mask, scanning `ptr, ptr+1, … 7, 0, … ptr-1`, with wrap-around modulo 8.
- FSM has two states, IDLE and VALID:
  - IDLE (`out_valid=0`): if `pending != 0`, load `out = select(pending)`, set `out_valid=1`, go to VALID. Otherwise stay.
  - VALID: `out` and `out_valid` are held stable while `out_ready=0`.
  - VALID on accept: `ptr <= out + 1`, wrapping 7→0. Let `rem = pending & ~onehot(out)`, evaluated with `ptr` already advanced to `out+1`. If `rem != 0`, load `out = select(rem)` and stay in VALID (back-to-back, no bubble). Else go to IDLE with `out_valid=0`.
- Requests captured in the same cycle as an accept are not visible to that cycle's selection. They are served on a later selection.
- `out` keeps its last value when `out_valid=0`. Consumers ignore it.

## Timing
- Reset, asynchronous on `rst_n=0`: `pending=0`, `out=0`, `out_valid=0`, `ovf=0`, `ptr=0`, state IDLE. Reset mid-transfer drops all pending requests with no completion.
- Latency from idle: request sampled at edge k sets `pending` at edge k. `out_valid` rises at edge k+1.
- Throughput: one index per cycle while `out_ready=1` and requests remain.
- `ovf` is registered and asserts one cycle after the offending capture.
- `out_ready` is not required to be held. `out_valid` never deasserts without an accept, except on reset.

## Structure
- Shared package `enc_pkg`: `N`, `W`, the FSM state encodings (`S_IDLE`, `S_VALID`), and the round-robin select function.
- Sub-module: instantiate the existing `dec3to8_case` with `en=acc` to produce `clr` from `out`. No new decoder is written.
- Everything else (pending register, pointer, FSM) lives in `enc8to3_rr`.

## Test plan
- Reset: with requests pending and `out_valid=1`, pulse `rst_n=0` asynchronously between clock edges. All outputs go to 0 immediately. The first code after release with `in=8'h10` is `out=4`.
- Single request: `en=1`, `in=8'b0010_0000` for one cycle, `out_ready=1`. `out_valid=1`, `out=5` appears one cycle after capture, for exactly one cycle. Then `pending=0`.
- Round-robin and wrap: `in=8'b1000_0101` for one cycle, `out_ready=1`. Codes 0, 2, 7 on consecutive cycles, then `ptr=0`. Next `in=8'h81` gives 0 then 7. A further `in=8'h81` after a single accept of 0 gives 7 before 0.
- Backpressure: `out_ready=0` with `out=3` presented. `out` stays 3 for 10 cycles. Then `in=8'h08` gives `ovf=1` for one cycle and `pending` is unchanged. Releasing `out_ready` drains the mask in round-robin order.
- Enable gating: `en=0`, `in=8'hFF` for 5 cycles. `pending` stays 0, `out_valid` stays 0, `ovf` stays 0.
- Set/clear collision: code 3 accepted in the same cycle that `in=8'h08` is captured. `pending[3]` remains 1, `ovf=0`, and index 3 is presented again after the other pending bits in round-robin order.
